// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if : handshake bundle between the register-file read stage, the
//              sequential ALU (alu_seq) and the writeback stage.
//
//   in_valid / in_ready  : operation request handshake (A, B, ALU_Sel)
//   out_valid / out_ready: result handshake (ALU_Out, CarryOut, Z)
//   busy                 : ALU is executing or holding a result
//   err                  : only present when ALU_SEQ_ERR_EN is defined;
//                          flags a result produced from an undefined opcode
//
// Modports: master = requester/consumer side, slave = the ALU.
// ---------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_Sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_Out;
    logic             CarryOut;
    logic             Z;
    logic             busy;
`ifdef ALU_SEQ_ERR_EN
    logic             err;

    modport master (
        output in_valid, A, B, ALU_Sel, out_ready,
        input  in_ready, out_valid, ALU_Out, CarryOut, Z, busy, err
    );

    modport slave (
        input  in_valid, A, B, ALU_Sel, out_ready,
        output in_ready, out_valid, ALU_Out, CarryOut, Z, busy, err
    );
`else
    modport master (
        output in_valid, A, B, ALU_Sel, out_ready,
        input  in_ready, out_valid, ALU_Out, CarryOut, Z, busy
    );

    modport slave (
        input  in_valid, A, B, ALU_Sel, out_ready,
        output in_ready, out_valid, ALU_Out, CarryOut, Z, busy
    );
`endif
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : sequential ALU. Accepts one operation over a valid/ready request
//           handshake, runs it in an IDLE/EXEC/DONE FSM and presents a
//           registered result with CarryOut and Z over a valid/ready result
//           handshake. Shifts take one cycle per bit of distance; MUL is an
//           unsigned shift-add multiplier taking WIDTH cycles.
//
// Parameters:
//   WIDTH   : operand/result width (>= 2)
//   SHIFT_W : shift-amount width, equal to clog2(WIDTH)
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_if.slave (in_valid, in_ready, A, B, ALU_Sel, out_valid,
//           out_ready, ALU_Out, CarryOut, Z, busy [, err])
//
// Optional feature: define ALU_SEQ_ERR_EN to add bus.err, which rises with
// out_valid for an undefined opcode and clears on the result handshake.
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int SHIFT_W = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_NOR = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_EQ  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_LT  = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1011;
    localparam logic [3:0] OP_SHR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1101;

    // One extra counter bit so a MUL can load the full WIDTH cycle count.
    localparam logic [SHIFT_W:0] CNT_ONE  = {{SHIFT_W{1'b0}}, 1'b1};
    localparam logic [SHIFT_W:0] CNT_FULL = (SHIFT_W+1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [WIDTH-1:0]     a_r;      // captured multiplicand
    logic [WIDTH-1:0]     a_s;
    logic [WIDTH-1:0]     work_r;   // shift working register
    logic [WIDTH-1:0]     work_s;
    logic [2*WIDTH-1:0]   acc_r;    // {partial product high, multiplier/low}
    logic [2*WIDTH-1:0]   acc_s;
    logic [3:0]           op_r;
    logic [3:0]           op_s;
    logic [SHIFT_W:0]     cnt_r;
    logic [SHIFT_W:0]     cnt_s;
    logic [WIDTH-1:0]     out_r;
    logic [WIDTH-1:0]     out_s;
    logic                 carry_r;
    logic                 carry_s;
    logic                 z_r;
    logic                 z_s;
    logic [WIDTH:0]       res_s;
    logic [WIDTH:0]       mul_sum_s;
    logic                 shift_bit_s;
    logic [SHIFT_W-1:0]   amt_s;
    logic                 is_shift_s;
    logic                 multi_s;

    // Single-cycle operations; bit WIDTH is the carry/borrow.
    function automatic logic [WIDTH:0] single_op(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [3:0]       sel
    );
        logic [WIDTH:0] r;
        r = '0;
        case (sel)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            // Borrow falls out as the top bit of the widened difference.
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_NOR:  r = {1'b0, ~(a | b)};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_EQ:   r = {1'b0, {(WIDTH-1){1'b0}}, (a == b)};
            OP_LT:   r = {1'b0, {(WIDTH-1){1'b0}}, (a < b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic op_defined(input logic [3:0] sel);
        logic d;
        case (sel)
            OP_ADD, OP_SUB, OP_NOR, OP_AND, OP_OR, OP_EQ, OP_XOR, OP_LT,
            OP_SHL, OP_SHR, OP_MUL: d = 1'b1;
            default:                d = 1'b0;
        endcase
        return d;
    endfunction

    assign amt_s      = bus.B[SHIFT_W-1:0];
    assign is_shift_s = (bus.ALU_Sel == OP_SHL) || (bus.ALU_Sel == OP_SHR);
    // A zero-distance shift completes like a single-cycle op.
    assign multi_s    = (bus.ALU_Sel == OP_MUL) ||
                        (is_shift_s && (amt_s != {SHIFT_W{1'b0}}));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    if (multi_s) begin
                        state_s = EXEC;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == CNT_ONE) begin
                    state_s = DONE;
                end else begin
                    state_s = EXEC;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath next values: capture on accept, one step per EXEC cycle,
    // result registers loaded only on entry to DONE.
    always_comb begin
        a_s         = a_r;
        work_s      = work_r;
        acc_s       = acc_r;
        op_s        = op_r;
        cnt_s       = cnt_r;
        out_s       = out_r;
        carry_s     = carry_r;
        z_s         = z_r;
        res_s       = '0;
        mul_sum_s   = '0;
        shift_bit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    a_s    = bus.A;
                    work_s = bus.A;
                    op_s   = bus.ALU_Sel;
                    acc_s  = {{WIDTH{1'b0}}, bus.B};
                    if (bus.ALU_Sel == OP_MUL) begin
                        cnt_s = CNT_FULL;
                    end else if (is_shift_s) begin
                        cnt_s = {1'b0, amt_s};
                    end else begin
                        cnt_s = '0;
                    end
                    if (!multi_s) begin
                        if (is_shift_s) begin
                            out_s   = bus.A;
                            carry_s = 1'b0;
                            z_s     = (bus.A == {WIDTH{1'b0}});
                        end else begin
                            res_s   = single_op(bus.A, bus.B, bus.ALU_Sel);
                            out_s   = res_s[WIDTH-1:0];
                            carry_s = res_s[WIDTH];
                            z_s     = (res_s[WIDTH-1:0] == {WIDTH{1'b0}});
                        end
                    end else begin
                        out_s = out_r;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            EXEC: begin
                cnt_s = cnt_r - CNT_ONE;
                if (op_r == OP_MUL) begin
                    // Add multiplicand into the high half when the current
                    // multiplier bit is set, then shift the pair right.
                    mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                                (acc_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
                    acc_s     = {mul_sum_s, acc_r[WIDTH-1:1]};
                    if (cnt_r == CNT_ONE) begin
                        out_s   = acc_s[WIDTH-1:0];
                        carry_s = |acc_s[2*WIDTH-1:WIDTH];
                        z_s     = (acc_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    end else begin
                        out_s = out_r;
                    end
                end else begin
                    if (op_r == OP_SHL) begin
                        work_s      = {work_r[WIDTH-2:0], 1'b0};
                        shift_bit_s = work_r[WIDTH-1];
                    end else begin
                        work_s      = {1'b0, work_r[WIDTH-1:1]};
                        shift_bit_s = work_r[0];
                    end
                    if (cnt_r == CNT_ONE) begin
                        out_s   = work_s;
                        carry_s = shift_bit_s;
                        z_s     = (work_s == {WIDTH{1'b0}});
                    end else begin
                        out_s = out_r;
                    end
                end
            end
            DONE:    out_s = out_r;
            default: out_s = out_r;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            work_r  <= '0;
            acc_r   <= '0;
            op_r    <= 4'b0000;
            cnt_r   <= '0;
            out_r   <= '0;
            carry_r <= 1'b0;
            z_r     <= 1'b0;
        end else begin
            a_r     <= a_s;
            work_r  <= work_s;
            acc_r   <= acc_s;
            op_r    <= op_s;
            cnt_r   <= cnt_s;
            out_r   <= out_s;
            carry_r <= carry_s;
            z_r     <= z_s;
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.busy      = (state_r != IDLE);
    assign bus.ALU_Out   = out_r;
    assign bus.CarryOut  = carry_r;
    assign bus.Z         = z_r;

`ifdef ALU_SEQ_ERR_EN
    logic err_r;
    logic err_s;

    // Error flag next value: set with the result of an undefined opcode.
    always_comb begin
        err_s = err_r;
        if ((state_r == IDLE) && bus.in_valid) begin
            err_s = !op_defined(bus.ALU_Sel);
        end else if ((state_r == DONE) && bus.out_ready) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_s;
        end
    end

    assign bus.err = err_r;
`endif

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_seq_if #(.WIDTH(8)) bus();

    alu_seq #(.WIDTH(8), .SHIFT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] e_out;
        logic       e_c;
        logic       e_z;
        int         e_lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic undef_op(input logic [3:0] sel);
        int s;
        s = int'(sel);
        return !((s >= 1 && s <= 8) || s == 11 || s == 12 || s == 13);
    endfunction

    // Behavioural reference computed with plain integer arithmetic.
    task automatic model(input int a, input int b, input int sel,
                         output int out, output int c, output int lat);
        int s;
        int p;
        s   = b % 8;
        out = 0;
        c   = 0;
        lat = 1;
        case (sel)
            1:  begin p = a + b; out = p % 256; c = (p >= 256) ? 1 : 0; end
            2:  begin out = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            3:  out = 255 - (a | b);
            4:  out = a & b;
            5:  out = a | b;
            6:  out = (a == b) ? 1 : 0;
            7:  out = a ^ b;
            8:  out = (a < b) ? 1 : 0;
            11: begin
                    out = (a * (1 << s)) % 256;
                    c   = (s == 0) ? 0 : ((a / (1 << (8 - s))) % 2);
                    lat = 1 + s;
                end
            12: begin
                    out = a / (1 << s);
                    c   = (s == 0) ? 0 : ((a / (1 << (s - 1))) % 2);
                    lat = 1 + s;
                end
            13: begin p = a * b; out = p % 256; c = (p >= 256) ? 1 : 0; lat = 9; end
            default: begin out = 0; c = 0; end
        endcase
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] sel, input logic [7:0] e_out,
                          input logic e_c, input logic e_z, input int e_lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.A        = a;
        bus.B        = b;
        bus.ALU_Sel  = sel;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        // Scramble the inputs: the result must come from the captured values.
        bus.A        = 8'($urandom);
        bus.B        = 8'($urandom);
        bus.ALU_Sel  = 4'($urandom);
        n = 1;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_lat"}, 32'(n), 32'(e_lat));
        check({name, "_out"}, 32'(bus.ALU_Out), 32'(e_out));
        check({name, "_carry"}, 32'(bus.CarryOut), 32'(e_c));
        check({name, "_z"}, 32'(bus.Z), 32'(e_z));
        check({name, "_busy"}, 32'(bus.busy), 32'd1);
        check({name, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
`ifdef ALU_SEQ_ERR_EN
        check({name, "_err"}, 32'(bus.err), 32'(undef_op(sel)));
`endif
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({name, "_released"}, 32'({bus.out_valid, bus.in_ready, bus.busy}), 32'b010);
`ifdef ALU_SEQ_ERR_EN
        check({name, "_err_clr"}, 32'(bus.err), 32'd0);
`endif
    endtask

    initial begin
        int eo;
        int ec;
        int el;
        int seen_valid;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [3:0] rs;
        checks = 0;
        errors = 0;

        vecs[0]  = '{"add_15_10",  8'd15,  8'd10,  4'b0001, 8'd25,  1'b0, 1'b0, 1};
        vecs[1]  = '{"add_200_100",8'd200, 8'd100, 4'b0001, 8'd44,  1'b1, 1'b0, 1};
        vecs[2]  = '{"sub_20_25",  8'd20,  8'd25,  4'b0010, 8'd251, 1'b1, 1'b0, 1};
        vecs[3]  = '{"sub_30_30",  8'd30,  8'd30,  4'b0010, 8'd0,   1'b0, 1'b1, 1};
        vecs[4]  = '{"eq_30_30",   8'd30,  8'd30,  4'b0110, 8'd1,   1'b0, 1'b0, 1};
        vecs[5]  = '{"shl_0f_3",   8'h0F,  8'd3,   4'b1011, 8'h78,  1'b0, 1'b0, 4};
        vecs[6]  = '{"shr_f1_1",   8'hF1,  8'd1,   4'b1100, 8'h78,  1'b1, 1'b0, 2};
        vecs[7]  = '{"shl_ab_0",   8'hAB,  8'd0,   4'b1011, 8'hAB,  1'b0, 1'b0, 1};
        vecs[8]  = '{"mul_13_11",  8'd13,  8'd11,  4'b1101, 8'h8F,  1'b0, 1'b0, 9};
        vecs[9]  = '{"mul_16_16",  8'd16,  8'd16,  4'b1101, 8'd0,   1'b1, 1'b1, 9};
        vecs[10] = '{"nor_f0_0f",  8'hF0,  8'h0F,  4'b0011, 8'h00,  1'b0, 1'b1, 1};
        vecs[11] = '{"lt_3_5",     8'd3,   8'd5,   4'b1000, 8'd1,   1'b0, 1'b0, 1};
        vecs[12] = '{"undef_0",    8'd5,   8'd6,   4'b0000, 8'd0,   1'b0, 1'b1, 1};
        vecs[13] = '{"xor_ff_0f",  8'hFF,  8'h0F,  4'b0111, 8'hF0,  1'b0, 1'b0, 1};
        vecs[14] = '{"shr_80_7",   8'h80,  8'd7,   4'b1100, 8'h01,  1'b0, 1'b0, 8};
        vecs[15] = '{"shl_03_7",   8'h03,  8'hF7,  4'b1011, 8'h80,  1'b1, 1'b0, 8};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = 8'd0;
        bus.B         = 8'd0;
        bus.ALU_Sel   = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'({bus.in_ready, bus.out_valid, bus.busy, bus.CarryOut, bus.Z}),
              32'b10000);
        check("reset_out", 32'(bus.ALU_Out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sel,
                   vecs[i].e_out, vecs[i].e_c, vecs[i].e_z, vecs[i].e_lat);
        end

        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 4'($urandom_range(0, 15));
            model(int'(ra), int'(rb), int'(rs), eo, ec, el);
            run_op("rand", ra, rb, rs, 8'(eo), ec[0], (eo == 0), el);
        end

        // Backpressure: result held, new request ignored until handshake.
        bus.A = 8'd1; bus.B = 8'd2; bus.ALU_Sel = 4'b0001; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.A = 8'd5; bus.B = 8'd5;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 32'({bus.out_valid, bus.in_ready, bus.CarryOut, bus.Z}), 32'b1000);
            check("bp_out", 32'(bus.ALU_Out), 32'd3);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_idle", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_new_valid", 32'(bus.out_valid), 32'd1);
        check("bp_new_out", 32'(bus.ALU_Out), 32'd10);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Asynchronous reset during MUL EXEC cycle 4.
        bus.A = 8'd13; bus.B = 8'd11; bus.ALU_Sel = 4'b1101; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_state", 32'({bus.in_ready, bus.out_valid, bus.busy, bus.CarryOut, bus.Z}),
              32'b10000);
        check("rst_async_out", 32'(bus.ALU_Out), 32'd0);
        seen_valid = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen_valid++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen_valid++;
        end
        check("rst_no_pulse", 32'(seen_valid), 32'd0);
        run_op("add_after_rst", 8'd1, 8'd1, 4'b0001, 8'd2, 1'b0, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, sequential successor to the 8-bit combinational ALU.
- Accepts one operation at a time over a valid/ready input handshake and runs it in a small FSM.
- Returns a registered result with CarryOut and Z flags over a valid/ready output handshake.
- Adds multi-cycle variable-distance shifts and a shift-add multiplier. Sits between the register-file read stage and the writeback stage.

Parameters:
- WIDTH, 8, operand and result width in bits (must be ≥ 2).
- SHIFT_W, 3, width of the shift-amount field taken from B; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept an operation.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; for shifts, B[SHIFT_W-1:0] is the shift amount.
- ALU_Sel  input  4  opcode.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- ALU_Out  output  WIDTH  result.
- CarryOut  output  1  carry, borrow, shifted-out bit or multiply overflow.
- Z  output  1  high when ALU_Out == 0.
- busy  output  1  high in EXEC or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: FSM in IDLE; in_ready=1; out_valid=0; ALU_Out=0; CarryOut=0; Z=0; busy=0. All internal operand, counter and accumulator registers are cleared.
- FSM states:
  - IDLE: in_ready=1.
  - EXEC: multi-cycle ops only.
  - DONE: out_valid=1.
- Accept: in_valid&&in_ready at edge N captures A, B and ALU_Sel. Inputs are ignored at every other time.
- Single-cycle ops: IDLE→DONE at edge N; out_valid is high from N+1.
  - 0001 ADD: {CarryOut,ALU_Out} = A+B.
  - 0010 SUB: ALU_Out = A−B mod 2^WIDTH; CarryOut = 1 when A<B unsigned (borrow).
  - 0011 NOR, 0100 AND, 0101 OR, 0111 XOR: bitwise; CarryOut=0.
  - 0110 EQ: ALU_Out = (A==B) zero-extended; CarryOut=0.
  - 1000 LT: ALU_Out = (A<B unsigned) zero-extended; CarryOut=0.
- Shifts, 1011 SHL and 1100 SHR (logical):
  - s = B[SHIFT_W-1:0]. IDLE→EXEC, shifting one bit per cycle for s cycles, then →DONE.
  - out_valid is high from N+1+s.
  - CarryOut = last bit shifted out; 0 when s=0.
  - s=0 goes directly IDLE→DONE with ALU_Out=A.
- 1101 MUL (unsigned shift-add):
  - WIDTH EXEC cycles; out_valid is high from N+1+WIDTH.
  - ALU_Out = low WIDTH bits of A*B.
  - CarryOut = 1 when the high WIDTH bits are nonzero.
- Undefined opcodes: single-cycle; ALU_Out=0, CarryOut=0, Z=1.
- Z is registered together with ALU_Out on entry to DONE.
- DONE: ALU_Out, CarryOut and Z are held stable until out_valid&&out_ready. At that edge the FSM goes →IDLE and out_valid falls.
- in_ready = (state==IDLE). There is no same-cycle bypass, so maximum throughput is one op per 2 cycles.
- busy = (state!=IDLE).
- Output flags are meaningful only while out_valid=1; after handshake they keep their last value.
- Reset mid-EXEC or mid-DONE aborts immediately: the pending result is lost and no out_valid pulse is produced.
- Counters must not wrap. The EXEC counter is SHIFT_W+1 bits wide so it can count to WIDTH.

Optional Feature:
- Macro: ALU_SEQ_ERR_EN.
- Defined: adds output port err (1 bit, reset 0). err is set together with out_valid when the accepted opcode is undefined, held through DONE, and cleared when the output handshake completes.
- Undefined: the err port and its logic are absent; undefined opcodes behave exactly as specified above.

Test Plan:
- ADD, WIDTH=8: A=15, B=10, ALU_Sel=0001 → out_valid one cycle after accept; ALU_Out=25, CarryOut=0, Z=0. A=200, B=100 → ALU_Out=44, CarryOut=1.
- SUB: A=20, B=25 → ALU_Out=251, CarryOut=1, Z=0. A=30, B=30 → ALU_Out=0, CarryOut=0, Z=1. EQ with A=B=30 → ALU_Out=1.
- Shifts: SHL A=0x0F, B=3 → ALU_Out=0x78, CarryOut=0, out_valid 4 cycles after accept. SHR A=0xF1, B=1 → ALU_Out=0x78, CarryOut=1, 2 cycles. SHL with B=0 → ALU_Out=A, 1 cycle.
- MUL: A=13, B=11 → ALU_Out=0x8F, CarryOut=0, out_valid 9 cycles after accept. A=16, B=16 → ALU_Out=0, CarryOut=1, Z=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → ALU_Out, flags and out_valid stable; in_ready=0; a new in_valid request is not accepted. Raise out_ready → IDLE next cycle and the new request is accepted.
- Reset: assert rst_n=0 asynchronously during MUL EXEC cycle 4 → all outputs return to reset values immediately with no out_valid pulse. A following ADD 1+1 returns 2.
